// File: rtl/acc_tx_port.sv
// 8N1 serial transmitter on the accumulator read side, with a one-entry
// holding buffer so a second output request can be queued behind the frame in flight.
module acc_tx_port #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       overrun
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shifter;
    logic [7:0]    buf_data;
    logic          buf_valid;
    logic          bit_end;
    logic          load_direct;
    logic          load_buf;
    logic          shift;
    logic          capture;
    logic          drop;

    always_comb begin
        state_nxt   = state;
        load_direct = 1'b0;
        load_buf    = 1'b0;
        shift       = 1'b0;
        bit_end     = (baud == BAUD_LAST);
        case (state)
            IDLE: begin
                if (tx_start) begin
                    state_nxt   = START;
                    load_direct = 1'b1;
                end
            end
            START: begin
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift = 1'b1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                // A pending buffered byte wins; otherwise a request landing in the
                // final stop cycle goes straight to the shifter so there is no idle gap.
                if (bit_end) begin
                    if (buf_valid) begin
                        state_nxt = START;
                        load_buf  = 1'b1;
                    end else if (tx_start) begin
                        state_nxt   = START;
                        load_direct = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        drop    = tx_start && buf_valid;
        capture = tx_start && !buf_valid && !load_direct;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= 3'd0;
            buf_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state   <= state_nxt;
            overrun <= drop;
            if (state == IDLE || bit_end) baud <= '0;
            else                          baud <= baud + BW'(1);
            if (state == START)           bit_idx <= 3'd0;
            else if (shift)               bit_idx <= bit_idx + 3'd1;
            if (load_buf)                 buf_valid <= 1'b0;
            else if (capture)             buf_valid <= 1'b1;
        end
    end

    // Byte storage carries no reset; buf_valid alone decides whether buf_data matters.
    always_ff @(posedge clk) begin
        if (load_direct)   shifter <= tx_data;
        else if (load_buf) shifter <= buf_data;
        else if (shift)    shifter <= {1'b0, shifter[7:1]};
        if (capture)       buf_data <= tx_data;
    end

    always_comb begin
        txd = 1'b1;
        if (state == START)     txd = 1'b0;
        else if (state == DATA) txd = shifter[0];
    end

    assign tx_busy  = (state != IDLE);
    assign tx_ready = !buf_valid;
    assign tx_done  = (state == STOP) && bit_end;

endmodule
